// File: rtl/comm_frame_master.sv
`default_nettype none
// ============================================================================
// Module      : comm_frame_master
// Description : UART command-frame master: sends cmd + payload bytes, then
//               waits for a one-byte response or a timeout.
//               Optional checksum byte enabled by macro COMM_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module comm_frame_master #(
    parameter int DATA_BYTES  = 2,
    parameter int TIMEOUT_CYC = 1250000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              cmd,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    send_cmd,
    output logic [7:0]              tx_data,
    output logic                    trmt,
    input  logic                    tx_done,
    input  logic                    rx_rdy,
    input  logic [7:0]              rx_data,
    output logic                    clr_rx_rdy,
    output logic                    frm_snt,
    output logic                    resp_rdy,
    output logic [7:0]              resp,
    input  logic                    clr_resp_rdy,
    output logic                    busy,
    output logic                    timeout
);

`ifdef COMM_CHKSUM_EN
    localparam int c_FRAME_LEN = DATA_BYTES + 2;
`else
    localparam int c_FRAME_LEN = DATA_BYTES + 1;
`endif
    localparam int c_CNT_W = $clog2(c_FRAME_LEN);
    localparam int c_TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_FRAME_LEN - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_END = c_TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_TX   = 2'd2,
        ST_WAIT_RESP = 2'd3
    } state_t;

    state_t                    r_state;
    logic [7:0]                r_cmd;
    logic [8*DATA_BYTES-1:0]   r_data;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_TMR_W-1:0]        r_tmr;
    logic [7:0]                r_tx_data;
    logic                      r_trmt;
    logic                      r_clr_rx_rdy;
    logic                      r_frm_snt;
    logic                      r_resp_rdy;
    logic [7:0]                r_resp;
    logic                      r_timeout;

    logic [7:0]                w_frame [c_FRAME_LEN];
    logic [c_CNT_W-1:0]        w_next_idx;
`ifdef COMM_CHKSUM_EN
    logic [7:0]                w_sum;
`endif

    // Frame image: cmd, then payload MSB first, then optional checksum
    always_comb begin
        w_frame[0] = r_cmd;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_frame[i+1] = r_data[8*(DATA_BYTES-1-i) +: 8];
        end
`ifdef COMM_CHKSUM_EN
        w_sum = r_cmd;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_sum = w_sum + r_data[8*i +: 8];
        end
        w_frame[DATA_BYTES+1] = ~w_sum;
`endif
    end

    assign w_next_idx = (r_cnt == c_LAST) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
            r_tmr        <= '0;
            r_tx_data    <= '0;
            r_trmt       <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
            r_frm_snt    <= 1'b0;
            r_resp_rdy   <= 1'b0;
            r_resp       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_trmt       <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
            // Placed ahead of the FSM so a same-cycle set overrides the clear
            if (clr_resp_rdy) begin
                r_resp_rdy <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (send_cmd) begin
                        r_cmd      <= cmd;
                        r_data     <= data;
                        r_frm_snt  <= 1'b0;
                        r_resp_rdy <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_cnt      <= '0;
                        r_tx_data  <= cmd;
                        r_trmt     <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        if (r_cnt == c_LAST) begin
                            r_frm_snt <= 1'b1;
                            r_tmr     <= '0;
                            r_state   <= ST_WAIT_RESP;
                        end else begin
                            r_cnt     <= w_next_idx;
                            r_tx_data <= w_frame[w_next_idx];
                            r_trmt    <= 1'b1;
                            r_state   <= ST_SEND;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (rx_rdy) begin
                        r_resp       <= rx_data;
                        r_resp_rdy   <= 1'b1;
                        r_clr_rx_rdy <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (r_tmr == c_TMR_END) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign trmt       = r_trmt;
    assign clr_rx_rdy = r_clr_rx_rdy;
    assign frm_snt    = r_frm_snt;
    assign resp_rdy   = r_resp_rdy;
    assign resp       = r_resp;
    assign timeout    = r_timeout;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_comm_frame_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_comm_frame_master
// Description : Self-checking bench; instance 0 has 2 payload bytes, instance 1
//               has 4. Honours COMM_CHKSUM_EN when building expected frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_frame_master;

    localparam int TO_A = 100;
    localparam int TO_B = 1200;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  send_v, tx_done_v, rx_rdy_v, clr_v;
    logic [15:0] cmd_v, rx_data_v;
    logic [15:0] data_a;
    logic [31:0] data_b;
    wire  [15:0] tx_data_v, resp_v;
    wire  [1:0]  trmt_v, clr_rx_v, frm_v, rrdy_v, busy_v, to_v;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q [$];
    logic        seen;

    always #5 clk = ~clk;

    comm_frame_master #(.DATA_BYTES(2), .TIMEOUT_CYC(TO_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_v[7:0]), .data(data_a),
        .send_cmd(send_v[0]), .tx_data(tx_data_v[7:0]), .trmt(trmt_v[0]),
        .tx_done(tx_done_v[0]), .rx_rdy(rx_rdy_v[0]), .rx_data(rx_data_v[7:0]),
        .clr_rx_rdy(clr_rx_v[0]), .frm_snt(frm_v[0]), .resp_rdy(rrdy_v[0]),
        .resp(resp_v[7:0]), .clr_resp_rdy(clr_v[0]), .busy(busy_v[0]),
        .timeout(to_v[0])
    );

    comm_frame_master #(.DATA_BYTES(4), .TIMEOUT_CYC(TO_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_v[15:8]), .data(data_b),
        .send_cmd(send_v[1]), .tx_data(tx_data_v[15:8]), .trmt(trmt_v[1]),
        .tx_done(tx_done_v[1]), .rx_rdy(rx_rdy_v[1]), .rx_data(rx_data_v[15:8]),
        .clr_rx_rdy(clr_rx_v[1]), .frm_snt(frm_v[1]), .resp_rdy(rrdy_v[1]),
        .resp(resp_v[15:8]), .clr_resp_rdy(clr_v[1]), .busy(busy_v[1]),
        .timeout(to_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int d);
        chk("reset_outputs",
            {10'd0, tx_data_v[8*d +: 8], resp_v[8*d +: 8], trmt_v[d], clr_rx_v[d],
             frm_v[d], rrdy_v[d], busy_v[d], to_v[d]}, 32'd0);
    endtask

    // Scoreboard model: cmd, payload MSB first, optional complemented sum
    task automatic build_expected(input int d, input logic [7:0] c, input logic [63:0] dat);
        logic [7:0] sum;
        logic [7:0] b;
        int nb;
        nb  = (d == 0) ? 2 : 4;
        sum = c;
        exp_q.delete();
        exp_q.push_back(c);
        for (int i = nb - 1; i >= 0; i--) begin
            b = dat[8*i +: 8];
            exp_q.push_back(b);
            sum = sum + b;
        end
`ifdef COMM_CHKSUM_EN
        exp_q.push_back(~sum);
`endif
    endtask

    task automatic send_frame(input int d, input logic [7:0] c, input logic [63:0] dat,
                              input int gap, input bit inject, input int abort_at);
        logic [7:0] b;
        int n;
        build_expected(d, c, dat);
        n = exp_q.size();
        cmd_v[8*d +: 8] = c;
        if (d == 0) data_a = dat[15:0]; else data_b = dat[31:0];
        send_v[d] = 1'b1;
        @(negedge clk);
        send_v[d] = 1'b0;
        cmd_v[8*d +: 8] = 8'hEE;
        if (d == 0) data_a = 16'($urandom); else data_b = $urandom;
        for (int i = 0; i < n; i++) begin
            b = exp_q.pop_front();
            chk("trmt_on", trmt_v[d], 1);
            chk("tx_byte", tx_data_v[8*d +: 8], b);
            chk("busy_tx", busy_v[d], 1);
            chk("frm_snt_low", frm_v[d], 0);
            if (i == 0) begin
                chk("resp_rdy_cleared", rrdy_v[d], 0);
                chk("timeout_cleared", to_v[d], 0);
            end
            if (i + 1 == abort_at) return;
            @(negedge clk);
            chk("trmt_pulse", trmt_v[d], 0);
            if (inject && i == 0) begin
                cmd_v[8*d +: 8] = 8'h77;
                if (d == 0) data_a = 16'h7777; else data_b = 32'h7777_7777;
                send_v[d] = 1'b1;
                @(negedge clk);
                send_v[d] = 1'b0;
            end
            repeat (gap) @(negedge clk);
            tx_done_v[d] = 1'b1;
            @(negedge clk);
            tx_done_v[d] = 1'b0;
        end
        chk("frm_snt_set", frm_v[d], 1);
        chk("busy_wait_resp", busy_v[d], 1);
        chk("no_trmt_after_last", trmt_v[d], 0);
    endtask

    task automatic respond(input int d, input int wait_cyc, input logic [7:0] b, input bit clr_same);
        repeat (wait_cyc) @(negedge clk);
        chk("busy_before_rx", busy_v[d], 1);
        rx_data_v[8*d +: 8] = b;
        rx_rdy_v[d] = 1'b1;
        clr_v[d]    = clr_same;
        @(negedge clk);
        rx_rdy_v[d] = 1'b0;
        clr_v[d]    = 1'b0;
        chk("clr_rx_rdy_pulse", clr_rx_v[d], 1);
        chk("resp_value", resp_v[8*d +: 8], b);
        chk("resp_rdy_set", rrdy_v[d], 1);
        chk("timeout_low", to_v[d], 0);
        chk("busy_idle", busy_v[d], 0);
        @(negedge clk);
        chk("clr_rx_rdy_one_cycle", clr_rx_v[d], 0);
        chk("resp_rdy_held", rrdy_v[d], 1);
    endtask

    initial begin
        send_v = '0; tx_done_v = '0; rx_rdy_v = '0; clr_v = '0;
        cmd_v = '0; rx_data_v = '0; data_a = '0; data_b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame; clear request coincides with the response set
        send_frame(0, 8'h06, 64'h0000, 3, 1'b0, 0);
        respond(0, 50, 8'hA5, 1'b1);

        // rx_rdy while idle is ignored
        rx_data_v[7:0] = 8'h33;
        rx_rdy_v[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_clr_rx", clr_rx_v[0], 0);
            chk("idle_resp_kept", resp_v[7:0], 8'hA5);
        end
        rx_rdy_v[0] = 1'b0;
        clr_v[0] = 1'b1;
        @(negedge clk);
        clr_v[0] = 1'b0;
        chk("resp_rdy_cleared_by_clr", rrdy_v[0], 0);

        // Four-byte payload, stray send_cmd during WAIT_TX, late response
        send_frame(1, 8'h01, 64'hDEAD_BEEF, 2, 1'b1, 0);
        respond(1, 1000, 8'h5A, 1'b0);

        // Timeout exactly TO_A cycles after final tx_done
        send_frame(0, 8'h02, 64'h1234, 1, 1'b0, 0);
        repeat (TO_A - 1) @(negedge clk);
        chk("timeout_not_yet", to_v[0], 0);
        chk("busy_before_timeout", busy_v[0], 1);
        @(negedge clk);
        chk("timeout_set", to_v[0], 1);
        chk("busy_after_timeout", busy_v[0], 0);
        chk("resp_rdy_after_timeout", rrdy_v[0], 0);
        chk("frm_snt_sticky", frm_v[0], 1);
        @(negedge clk);
        chk("timeout_sticky", to_v[0], 1);

        // rx_rdy on the terminal-count cycle wins
        send_frame(0, 8'h4B, 64'hC0DE, 0, 1'b0, 0);
        respond(0, TO_A - 1, 8'h99, 1'b0);
        clr_v[0] = 1'b1;
        @(negedge clk);
        clr_v[0] = 1'b0;
        chk("tie_resp_rdy_cleared", rrdy_v[0], 0);
        chk("tie_timeout_low", to_v[0], 0);

        // Reset after the second trmt aborts the frame
        send_frame(0, 8'h3C, 64'h55AA, 2, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | trmt_v[0];
        end
        chk("no_trmt_after_reset", seen, 0);
        chk("idle_after_reset", busy_v[0], 0);
        send_frame(0, 8'hA1, 64'h0F0F, 1, 1'b0, 0);
        respond(0, 5, 8'hC3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
